// File: rtl/infernet_pkg.sv
// Shared definitions for the inference-frame receive path.
// Holds the default field/counter widths, the default payload size of one
// inference frame (a 28x28 8-bit image) and the frame assembler state type.
package infernet_pkg;

  localparam int unsigned UserDataBytesDefault = 784;
  localparam int unsigned IpAddrWidthDefault   = 32;
  localparam int unsigned MacAddrWidthDefault  = 48;
  localparam int unsigned UdpPortWidthDefault  = 16;
  localparam int unsigned DropCntWidthDefault  = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRecv  = 2'd1,
    StDrain = 2'd2,
    StHold  = 2'd3
  } rx_state_e;

  // Width of a byte index over n bytes; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset, clears the count
//   inc_i   - add one this cycle (ignored once the count is all-ones)
//   count_o - registered count value
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/udp_rx_frame_assembler.sv
// UDP receive frame assembler.
// Collects a fixed-size UDP payload (USER_DATA_BYTES bytes) from a byte-wide
// AXI-Stream into a flat frame register, together with the sender's IP, MAC
// and UDP port, and hands the complete frame to the inference stage with a
// one-cycle FRAME_READY pulse once that stage is not busy. Short and long
// frames are discarded and counted in DROP_COUNT (saturating).
// Ports:
//   ACLK, ARESET             - clock (rising edge) and async active-low reset
//   S_AXIS_TDATA/TVALID/TLAST/TREADY - payload byte stream
//   HDR_VALID, SRC_*_IN      - header of the frame that follows, valid for one cycle
//   NN_BUSY                  - downstream cannot accept a frame
//   DATA_FRAME_IP            - assembled payload, byte k at bits [k*8 +: 8]
//   SRC_*_IP                 - header of the delivered frame
//   FRAME_READY              - one-cycle pulse: outputs hold a new frame
//   DROP_COUNT               - number of malformed frames dropped
module udp_rx_frame_assembler
  import infernet_pkg::*;
#(
  parameter int unsigned USER_DATA_BYTES = UserDataBytesDefault,
  parameter int unsigned IP_ADDR_WIDTH   = IpAddrWidthDefault,
  parameter int unsigned MAC_ADDR_WIDTH  = MacAddrWidthDefault,
  parameter int unsigned UDP_PORT_WIDTH  = UdpPortWidthDefault,
  parameter int unsigned DROP_CNT_WIDTH  = DropCntWidthDefault
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [7:0]                    S_AXIS_TDATA,
  input  logic                          S_AXIS_TVALID,
  input  logic                          S_AXIS_TLAST,
  output logic                          S_AXIS_TREADY,
  input  logic                          HDR_VALID,
  input  logic [IP_ADDR_WIDTH-1:0]      SRC_IP_ADDRESS_IN,
  input  logic [MAC_ADDR_WIDTH-1:0]     SRC_MAC_ADDRESS_IN,
  input  logic [UDP_PORT_WIDTH-1:0]     SRC_UDP_PORT_IN,
  input  logic                          NN_BUSY,
  output logic [0:USER_DATA_BYTES*8-1]  DATA_FRAME_IP,
  output logic [IP_ADDR_WIDTH-1:0]      SRC_IP_ADDRESS_IP,
  output logic [MAC_ADDR_WIDTH-1:0]     SRC_MAC_ADDRESS_IP,
  output logic [UDP_PORT_WIDTH-1:0]     SRC_UDP_PORT_IP,
  output logic                          FRAME_READY,
  output logic [DROP_CNT_WIDTH-1:0]     DROP_COUNT
);

  localparam int unsigned CntW = cnt_width(USER_DATA_BYTES);
  localparam logic [CntW-1:0] LastIdx = CntW'(USER_DATA_BYTES - 1);

  rx_state_e state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic tready_d, tready_q;
  logic frame_ready_d, frame_ready_q;

  // Header staging: captured at HDR_VALID, published only when the frame is handed over.
  logic [IP_ADDR_WIDTH-1:0]  stg_ip_d, stg_ip_q;
  logic [MAC_ADDR_WIDTH-1:0] stg_mac_d, stg_mac_q;
  logic [UDP_PORT_WIDTH-1:0] stg_port_d, stg_port_q;

  logic [IP_ADDR_WIDTH-1:0]  src_ip_d, src_ip_q;
  logic [MAC_ADDR_WIDTH-1:0] src_mac_d, src_mac_q;
  logic [UDP_PORT_WIDTH-1:0] src_port_d, src_port_q;

  // Payload is written straight into the output register, so the previous
  // frame stays visible until the first byte of the next one lands.
  logic [0:USER_DATA_BYTES*8-1] data_d, data_q;

  logic            beat;
  logic            take_byte;
  logic [CntW-1:0] wr_idx;
  logic            drop_inc;

  assign beat = S_AXIS_TVALID & tready_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    stg_ip_d      = stg_ip_q;
    stg_mac_d     = stg_mac_q;
    stg_port_d    = stg_port_q;
    src_ip_d      = src_ip_q;
    src_mac_d     = src_mac_q;
    src_port_d    = src_port_q;
    frame_ready_d = 1'b0;
    drop_inc      = 1'b0;
    take_byte     = 1'b0;
    wr_idx        = cnt_q;

    unique case (state_q)
      StIdle: begin
        // Beats without a header are discarded; a beat coinciding with the
        // header is the first payload byte.
        if (HDR_VALID) begin
          stg_ip_d   = SRC_IP_ADDRESS_IN;
          stg_mac_d  = SRC_MAC_ADDRESS_IN;
          stg_port_d = SRC_UDP_PORT_IN;
          cnt_d      = '0;
          state_d    = StRecv;
          if (beat) begin
            take_byte = 1'b1;
            wr_idx    = '0;
          end
        end
      end
      StRecv: begin
        if (beat) begin
          take_byte = 1'b1;
        end
      end
      StDrain: begin
        if (beat && S_AXIS_TLAST) begin
          drop_inc = 1'b1;
          state_d  = StIdle;
        end
      end
      StHold: begin
        if (!NN_BUSY) begin
          src_ip_d      = stg_ip_q;
          src_mac_d     = stg_mac_q;
          src_port_d    = stg_port_q;
          frame_ready_d = 1'b1;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take_byte) begin
      data_d[{wr_idx, 3'b000} +: 8] = S_AXIS_TDATA;
      if (wr_idx == LastIdx) begin
        state_d = S_AXIS_TLAST ? StHold : StDrain;
      end else if (S_AXIS_TLAST) begin
        drop_inc = 1'b1;
        state_d  = StIdle;
      end else begin
        cnt_d = wr_idx + CntW'(1);
      end
    end

    // Registered ready: low while a completed frame waits for the consumer.
    tready_d = (state_d != StHold);
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      tready_q      <= 1'b0;
      frame_ready_q <= 1'b0;
      stg_ip_q      <= '0;
      stg_mac_q     <= '0;
      stg_port_q    <= '0;
      src_ip_q      <= '0;
      src_mac_q     <= '0;
      src_port_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tready_q      <= tready_d;
      frame_ready_q <= frame_ready_d;
      stg_ip_q      <= stg_ip_d;
      stg_mac_q     <= stg_mac_d;
      stg_port_q    <= stg_port_d;
      src_ip_q      <= src_ip_d;
      src_mac_q     <= src_mac_d;
      src_port_q    <= src_port_d;
    end
  end

  // Frame storage carries no reset; it is only meaningful alongside FRAME_READY.
  always_ff @(posedge ACLK) begin
    data_q <= data_d;
  end

  sat_counter #(
    .Width (DROP_CNT_WIDTH)
  ) u_drop_cnt (
    .clk_i   (ACLK),
    .rst_ni  (ARESET),
    .inc_i   (drop_inc),
    .count_o (DROP_COUNT)
  );

  assign S_AXIS_TREADY      = tready_q;
  assign FRAME_READY        = frame_ready_q;
  assign DATA_FRAME_IP      = data_q;
  assign SRC_IP_ADDRESS_IP  = src_ip_q;
  assign SRC_MAC_ADDRESS_IP = src_mac_q;
  assign SRC_UDP_PORT_IP    = src_port_q;

endmodule

// File: tb/tb_udp_rx_frame_assembler.sv
// Self-checking bench for udp_rx_frame_assembler.
// A frame-level model (queue of expected delivered frames plus an expected
// drop count) is checked every cycle; directed sequences add timing and
// literal checks.
module tb_udp_rx_frame_assembler;
  import infernet_pkg::*;

  localparam int unsigned N  = 784;
  localparam int unsigned FW = N * 8;

  logic          ACLK;
  logic          ARESET;
  logic [7:0]    S_AXIS_TDATA;
  logic          S_AXIS_TVALID;
  logic          S_AXIS_TLAST;
  logic          S_AXIS_TREADY;
  logic          HDR_VALID;
  logic [31:0]   SRC_IP_ADDRESS_IN;
  logic [47:0]   SRC_MAC_ADDRESS_IN;
  logic [15:0]   SRC_UDP_PORT_IN;
  logic          NN_BUSY;
  logic [0:FW-1] DATA_FRAME_IP;
  logic [31:0]   SRC_IP_ADDRESS_IP;
  logic [47:0]   SRC_MAC_ADDRESS_IP;
  logic [15:0]   SRC_UDP_PORT_IP;
  logic          FRAME_READY;
  logic [15:0]   DROP_COUNT;

  logic          sc_rst_n;
  logic          sc_inc;
  logic [2:0]    sc_count;

  udp_rx_frame_assembler dut (
    .ACLK               (ACLK),
    .ARESET             (ARESET),
    .S_AXIS_TDATA       (S_AXIS_TDATA),
    .S_AXIS_TVALID      (S_AXIS_TVALID),
    .S_AXIS_TLAST       (S_AXIS_TLAST),
    .S_AXIS_TREADY      (S_AXIS_TREADY),
    .HDR_VALID          (HDR_VALID),
    .SRC_IP_ADDRESS_IN  (SRC_IP_ADDRESS_IN),
    .SRC_MAC_ADDRESS_IN (SRC_MAC_ADDRESS_IN),
    .SRC_UDP_PORT_IN    (SRC_UDP_PORT_IN),
    .NN_BUSY            (NN_BUSY),
    .DATA_FRAME_IP      (DATA_FRAME_IP),
    .SRC_IP_ADDRESS_IP  (SRC_IP_ADDRESS_IP),
    .SRC_MAC_ADDRESS_IP (SRC_MAC_ADDRESS_IP),
    .SRC_UDP_PORT_IP    (SRC_UDP_PORT_IP),
    .FRAME_READY        (FRAME_READY),
    .DROP_COUNT         (DROP_COUNT)
  );

  // Narrow instance to reach saturation quickly.
  sat_counter #(
    .Width (3)
  ) u_sat (
    .clk_i   (ACLK),
    .rst_ni  (sc_rst_n),
    .inc_i   (sc_inc),
    .count_o (sc_count)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [0:FW-1] data;
    logic [31:0]   ip;
    logic [47:0]   mac;
    logic [15:0]   port;
  } frame_t;

  frame_t exp_q[$];
  int     checks   = 0;
  int     failures = 0;
  int     exp_drop = 0;
  int     pulses   = 0;
  logic   fr_prev  = 1'b0;

  localparam logic [31:0] IpA   = 32'h01020304;
  localparam logic [47:0] MacA  = 48'hdeadbeefb00b;
  localparam logic [15:0] PortA = 16'd666;
  localparam logic [47:0] MacB  = 48'hbed1becc1122;
  localparam logic [15:0] PortB = 16'd999;

  function automatic logic [7:0] pat(input int kind, input int i);
    case (kind)
      0:       return 8'(i % 27);
      1:       return 8'((i * 7 + 3) % 256);
      default: return 8'((i * 13 + 5) % 256);
    endcase
  endfunction

  function automatic logic [0:FW-1] build_vec(input int kind);
    logic [0:FW-1] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = pat(kind, i);
    return v;
  endfunction

  function automatic logic [7:0] byte_at(input logic [0:FW-1] v, input int i);
    return v[i*8 +: 8];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [0:FW-1] act,
                           input logic [0:FW-1] exp);
    int idx;
    checks++;
    if (act !== exp) begin
      failures++;
      idx = 0;
      while (idx < N && byte_at(act, idx) === byte_at(exp, idx)) idx++;
      $display("FAIL %s: byte %0d got %02h expected %02h (t=%0t)", name, idx,
               byte_at(act, idx), byte_at(exp, idx), $time);
    end
  endtask

  // Per-cycle compare against the frame-level model.
  always @(negedge ACLK) begin
    frame_t f;
    if (ARESET) begin
      check("drop_count", 64'(DROP_COUNT), 64'(exp_drop));
      if (FRAME_READY) begin
        pulses++;
        check("frame_ready_width", 64'(fr_prev), 64'd0);
        check("frame_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          f = exp_q.pop_front();
          check_vec("frame_data", DATA_FRAME_IP, f.data);
          check("frame_ip", 64'(SRC_IP_ADDRESS_IP), 64'(f.ip));
          check("frame_mac", 64'(SRC_MAC_ADDRESS_IP), 64'(f.mac));
          check("frame_port", 64'(SRC_UDP_PORT_IP), 64'(f.port));
        end
      end
      fr_prev = FRAME_READY;
    end else begin
      fr_prev = 1'b0;
    end
  end

  // One beat; entered and left at posedge+1, returns once the beat is taken.
  task automatic beat(input logic [7:0] d, input logic last);
    bit done;
    done = 1'b0;
    S_AXIS_TDATA  = d;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TLAST  = last;
    for (int c = 0; c < 200 && !done; c++) begin
      done = S_AXIS_TREADY;
      @(posedge ACLK);
      #1;
    end
    if (!done) begin
      $display("FAIL beat_accept: TREADY stuck low got 0 expected 1 (t=%0t)", $time);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "beat timeout");
    end
  endtask

  task automatic send_frame(input int n, input int kind, input logic [31:0] ip,
                            input logic [47:0] mac, input logic [15:0] port,
                            input bit gaps, input int abort_at);
    frame_t f;
    HDR_VALID          = 1'b1;
    SRC_IP_ADDRESS_IN  = ip;
    SRC_MAC_ADDRESS_IN = mac;
    SRC_UDP_PORT_IN    = port;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        #2;
        ARESET   = 1'b0;
        exp_drop = 0;
        exp_q.delete();
        #1;
        check("rst_tready", 64'(S_AXIS_TREADY), 64'd0);
        check("rst_frame_ready", 64'(FRAME_READY), 64'd0);
        check("rst_drop", 64'(DROP_COUNT), 64'd0);
        check("rst_ip", 64'(SRC_IP_ADDRESS_IP), 64'd0);
        check("rst_mac", 64'(SRC_MAC_ADDRESS_IP), 64'd0);
        check("rst_port", 64'(SRC_UDP_PORT_IP), 64'd0);
        @(negedge ACLK);
        #1;
        ARESET = 1'b1;
        check("rel_tready_before_edge", 64'(S_AXIS_TREADY), 64'd0);
        @(posedge ACLK);
        #1;
        check("rel_tready_after_edge", 64'(S_AXIS_TREADY), 64'd1);
        return;
      end
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(1) == 1; g++) begin
          S_AXIS_TVALID = 1'b0;
          @(posedge ACLK);
          #1;
          HDR_VALID = 1'b0;
        end
      end
      if (i == 100) begin
        // Stray header mid-frame must be ignored.
        HDR_VALID          = 1'b1;
        SRC_IP_ADDRESS_IN  = ~ip;
        SRC_MAC_ADDRESS_IN = ~mac;
        SRC_UDP_PORT_IN    = ~port;
      end
      beat(pat(kind, i), i == n - 1);
      HDR_VALID = 1'b0;
      if (i < N) f.data[i*8 +: 8] = pat(kind, i);
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    if (n == N) begin
      f.ip   = ip;
      f.mac  = mac;
      f.port = port;
      exp_q.push_back(f);
    end else if (exp_drop < 65535) begin
      exp_drop++;
    end
  endtask

  task automatic wait_ready(input string name);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge ACLK);
      #1;
      got = FRAME_READY;
    end
    check(name, 64'(got), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    ARESET             = 1'b1;
    S_AXIS_TDATA       = '0;
    S_AXIS_TVALID      = 1'b0;
    S_AXIS_TLAST       = 1'b0;
    HDR_VALID          = 1'b0;
    SRC_IP_ADDRESS_IN  = '0;
    SRC_MAC_ADDRESS_IN = '0;
    SRC_UDP_PORT_IN    = '0;
    NN_BUSY            = 1'b0;
    sc_rst_n           = 1'b0;
    sc_inc             = 1'b0;
    #2;
    ARESET = 1'b0;
    #21;
    check("reset_tready", 64'(S_AXIS_TREADY), 64'd0);
    check("reset_frame_ready", 64'(FRAME_READY), 64'd0);
    check("reset_drop", 64'(DROP_COUNT), 64'd0);
    check("reset_ip", 64'(SRC_IP_ADDRESS_IP), 64'd0);
    check("reset_mac", 64'(SRC_MAC_ADDRESS_IP), 64'd0);
    check("reset_port", 64'(SRC_UDP_PORT_IP), 64'd0);
    @(negedge ACLK);
    #1;
    ARESET = 1'b1;
    check("release_tready_pre", 64'(S_AXIS_TREADY), 64'd0);
    @(posedge ACLK);
    #1;
    check("release_tready_post", 64'(S_AXIS_TREADY), 64'd1);

    // Basic frame, consumer idle.
    send_frame(N, 0, IpA, MacA, PortA, 1'b0, -1);
    @(negedge ACLK);
    check("hold_tready", 64'(S_AXIS_TREADY), 64'd0);
    check("fr_early", 64'(FRAME_READY), 64'd0);
    @(negedge ACLK);
    check("fr_timing", 64'(FRAME_READY), 64'd1);
    check("lit_byte0", 64'(DATA_FRAME_IP[0:7]), 64'd0);
    check("lit_byte26", 64'(DATA_FRAME_IP[26*8 +: 8]), 64'd26);
    check("lit_byte27", 64'(DATA_FRAME_IP[27*8 +: 8]), 64'd0);
    check("lit_byte500", 64'(DATA_FRAME_IP[500*8 +: 8]), 64'd14);
    check("lit_byte782", 64'(DATA_FRAME_IP[782*8 +: 8]), 64'd26);
    check("lit_byte783", 64'(DATA_FRAME_IP[783*8 +: 8]), 64'd0);
    check("lit_mac", 64'(SRC_MAC_ADDRESS_IP), 64'hdeadbeefb00b);
    check("lit_ip", 64'(SRC_IP_ADDRESS_IP), 64'h01020304);
    check("lit_port", 64'(SRC_UDP_PORT_IP), 64'd666);
    check("lit_drop0", 64'(DROP_COUNT), 64'd0);
    repeat (10) @(posedge ACLK);
    #1;
    check("idle_tready", 64'(S_AXIS_TREADY), 64'd1);
    check_vec("data_stable", DATA_FRAME_IP, build_vec(0));

    // Consumer busy for 50 cycles after the last byte.
    NN_BUSY = 1'b1;
    send_frame(N, 1, IpA, MacA, PortA, 1'b0, -1);
    for (int c = 0; c < 50; c++) begin
      @(negedge ACLK);
      check("busy_tready", 64'(S_AXIS_TREADY), 64'd0);
      check("busy_no_fr", 64'(FRAME_READY), 64'd0);
    end
    @(posedge ACLK);
    #1;
    NN_BUSY = 1'b0;
    @(negedge ACLK);
    check("busy_fr_not_yet", 64'(FRAME_READY), 64'd0);
    @(negedge ACLK);
    check("busy_fr_pulse", 64'(FRAME_READY), 64'd1);
    check("lit_busy_byte1", 64'(DATA_FRAME_IP[8 +: 8]), 64'd10);
    @(posedge ACLK);
    #1;

    // Short frame, then a good frame.
    send_frame(500, 2, IpA, MacA, PortA, 1'b0, -1);
    repeat (5) @(posedge ACLK);
    #1;
    check("lit_drop_short", 64'(DROP_COUNT), 64'd1);
    send_frame(N, 0, IpA, MacB, PortB, 1'b0, -1);
    wait_ready("after_short_ready");
    @(posedge ACLK);
    #1;

    // Long frame drains; stored bytes are the first N of the long frame.
    check_vec("data_before_long", DATA_FRAME_IP, build_vec(0));
    send_frame(800, 1, IpA, MacA, PortA, 1'b0, -1);
    repeat (5) @(posedge ACLK);
    #1;
    check("lit_drop_long", 64'(DROP_COUNT), 64'd2);
    check_vec("data_after_long", DATA_FRAME_IP, build_vec(1));
    check("lit_long_byte783", 64'(DATA_FRAME_IP[783*8 +: 8]), 64'd108);

    // Reset at byte 300, then a full frame with a new header.
    send_frame(N, 2, IpA, MacA, PortA, 1'b0, 300);
    send_frame(N, 0, IpA, MacB, PortB, 1'b0, -1);
    wait_ready("after_reset_ready");
    @(negedge ACLK);
    check("lit_reset_mac", 64'(SRC_MAC_ADDRESS_IP), 64'hbed1becc1122);
    check("lit_reset_port", 64'(SRC_UDP_PORT_IP), 64'd999);
    check("lit_reset_drop", 64'(DROP_COUNT), 64'd0);
    @(posedge ACLK);
    #1;

    // Two frames with random valid gaps, second started in the FRAME_READY cycle.
    p0 = pulses;
    send_frame(N, 1, IpA, MacA, PortA, 1'b1, -1);
    wait_ready("gap_ready1");
    send_frame(N, 2, IpA, MacB, PortB, 1'b1, -1);
    wait_ready("gap_ready2");
    repeat (10) @(posedge ACLK);
    #1;
    check("gap_pulse_count", 64'(pulses - p0), 64'd2);
    check("model_queue_empty", 64'(exp_q.size()), 64'd0);

    // Saturation of a 3-bit counter.
    sc_rst_n = 1'b1;
    sc_inc   = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check("sat_count3", 64'(sc_count), 64'd3);
    repeat (7) @(posedge ACLK);
    #1;
    check("sat_count_max", 64'(sc_count), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
